// File: rtl/d_mem_pkg.sv
// Shared types and constants for the data-memory controller.
package d_mem_pkg;

    localparam int unsigned BUS_WIDTH      = 32;
    localparam int unsigned BYTES_PER_WORD = 4;
    localparam int unsigned OFFSET_W       = 2;

    localparam logic [1:0] BYTE         = 2'b00;
    localparam logic [1:0] HALF_WORD    = 2'b01;
    localparam logic [1:0] WORD         = 2'b10;
    localparam logic [1:0] SIZE_ILLEGAL = 2'b11;

    typedef enum logic [0:0] {
        StIdle,
        StSplit
    } state_e;

    // Byte-lane mask of an access starting at lane 0.
    function automatic logic [BYTES_PER_WORD-1:0] size_mask(input logic [1:0] size);
        case (size)
            BYTE:      return 4'b0001;
            HALF_WORD: return 4'b0011;
            default:   return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/d_mem_ctrl_if.sv
// Request/response bus between a core load-store unit and d_mem_ctrl.
interface d_mem_ctrl_if;
    import d_mem_pkg::*;

    logic                 req_valid;
    logic                 req_ready;
    logic [BUS_WIDTH-1:0] req_addr;
    logic                 req_wr_en;
    logic [BUS_WIDTH-1:0] req_wr_data;
    logic [1:0]           req_size;
    logic                 req_sz_ex;
    logic                 rsp_valid;
    logic [BUS_WIDTH-1:0] rsp_data;
    logic                 rsp_err;

    modport master (
        output req_valid, req_addr, req_wr_en, req_wr_data, req_size, req_sz_ex,
        input  req_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  req_valid, req_addr, req_wr_en, req_wr_data, req_size, req_sz_ex,
        output req_ready, rsp_valid, rsp_data, rsp_err
    );

endinterface

// File: rtl/d_mem_ext.sv
// Load formatter: merges two words, selects the addressed lanes and applies
// sign or zero extension.
module d_mem_ext
    import d_mem_pkg::*;
(
    input  logic [BUS_WIDTH-1:0] lo_word,
    input  logic [BUS_WIDTH-1:0] hi_word,
    input  logic [1:0]           offset,
    input  logic [1:0]           size,
    input  logic                 sz_ex,
    output logic [BUS_WIDTH-1:0] data
);

    logic [BUS_WIDTH-1:0] aligned;

    always_comb begin
        // hi_word only carries real bytes for word-crossing loads.
        aligned = 32'({hi_word, lo_word} >> {offset, 3'b000});
        case (size)
            BYTE:      data = {{24{sz_ex & aligned[7]}}, aligned[7:0]};
            HALF_WORD: data = {{16{sz_ex & aligned[15]}}, aligned[15:0]};
            default:   data = aligned;
        endcase
    end

endmodule

// File: rtl/d_mem_ctrl.sv
// Data-memory controller: byte/half/word array plus memory-mapped IO registers.
// Define D_MEM_MISALIGN_EN to support misaligned array accesses (split in two cycles).
module d_mem_ctrl
    import d_mem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 64,
    parameter int unsigned IO_CHANNELS = 4,
    parameter int unsigned IO_BASE     = 256
) (
    input  logic                             clk,
    input  logic                             rst,
    d_mem_ctrl_if.slave                      bus,
    output logic [BUS_WIDTH*IO_CHANNELS-1:0] mem_map_io
);

    localparam int unsigned IDX_W       = $clog2(DEPTH_WORDS);
    localparam int unsigned ARRAY_BYTES = BYTES_PER_WORD * DEPTH_WORDS;
    localparam int unsigned IO_END      = IO_BASE + BYTES_PER_WORD * IO_CHANNELS;
    localparam int unsigned IO_IDX_W    = (IO_CHANNELS > 1) ? $clog2(IO_CHANNELS) : 1;

    logic [BUS_WIDTH-1:0] mem [DEPTH_WORDS];
    logic [BUS_WIDTH-1:0] io_q [IO_CHANNELS];

    logic                 rsp_valid_q;
    logic                 rsp_err_q;
    logic [BUS_WIDTH-1:0] rsp_data_q;

    logic                 accept;
    logic                 in_array;
    logic                 in_io;
    logic                 err;
    logic                 split;
    logic [OFFSET_W-1:0]  off;
    logic [IDX_W-1:0]     idx;
    logic [IO_IDX_W-1:0]  io_idx;
    logic [3:0]           lo_mask;
    logic [BUS_WIDTH-1:0] lo_wdata;

    logic                 mem_we;
    logic [IDX_W-1:0]     mem_widx;
    logic [3:0]           mem_mask;
    logic [BUS_WIDTH-1:0] mem_wdata;

    logic [BUS_WIDTH-1:0] ext_lo;
    logic [BUS_WIDTH-1:0] ext_hi;
    logic [BUS_WIDTH-1:0] ext_data;
    logic [1:0]           ext_off;
    logic [1:0]           ext_size;
    logic                 ext_sx;

`ifdef D_MEM_MISALIGN_EN
    state_e               state_q;
    logic                 ready_q;
    logic [IDX_W-1:0]     hold_idx_q;
    logic [1:0]           hold_off_q;
    logic [1:0]           hold_size_q;
    logic                 hold_sx_q;
    logic                 hold_wr_q;
    logic [3:0]           hold_mask_q;
    logic [BUS_WIDTH-1:0] hold_wdata_q;
    logic [BUS_WIDTH-1:0] hold_lo_q;
    logic                 cross;
    logic [IDX_W-1:0]     idx_next;
    logic [3:0]           hi_mask;
    logic [BUS_WIDTH-1:0] hi_wdata;
`else
    logic                 misalign;
`endif

    always_comb begin
        off      = bus.req_addr[1:0];
        idx      = bus.req_addr[IDX_W+1:2];
        io_idx   = IO_IDX_W'((bus.req_addr - IO_BASE) >> 2);
        in_array = bus.req_addr < ARRAY_BYTES;
        in_io    = (bus.req_addr >= IO_BASE) && (bus.req_addr < IO_END);
        accept   = bus.req_valid && bus.req_ready;
        err      = 1'b0;
        split    = 1'b0;
`ifdef D_MEM_MISALIGN_EN
        cross    = ((bus.req_size == WORD) && (off != 2'd0)) ||
                   ((bus.req_size == HALF_WORD) && (off == 2'd3));
        idx_next = idx + IDX_W'(1);
        {hi_mask, lo_mask}   = {4'b0000, size_mask(bus.req_size)} << off;
        {hi_wdata, lo_wdata} = {32'h0, bus.req_wr_data} << {off, 3'b000};
`else
        misalign = ((bus.req_size == HALF_WORD) && off[0]) ||
                   ((bus.req_size == WORD) && (off != 2'd0));
        lo_mask  = size_mask(bus.req_size) << off;
        lo_wdata = bus.req_wr_data << {off, 3'b000};
`endif
        if (bus.req_size == SIZE_ILLEGAL) begin
            err = 1'b1;
        end else if (in_io) begin
            err = (bus.req_size != WORD) || (off != 2'd0);
        end else if (in_array) begin
`ifdef D_MEM_MISALIGN_EN
            // Second half must also land inside the array.
            err   = cross && (idx == IDX_W'(DEPTH_WORDS - 1));
            split = cross && !err;
`else
            err = misalign;
`endif
        end else begin
            err = 1'b1;
        end
    end

    // Single write port: lower word at acceptance, upper word during the split cycle.
    always_comb begin
        mem_we    = accept && bus.req_wr_en && in_array && !err;
        mem_widx  = idx;
        mem_mask  = lo_mask;
        mem_wdata = lo_wdata;
`ifdef D_MEM_MISALIGN_EN
        if (state_q == StSplit) begin
            mem_we    = hold_wr_q;
            mem_widx  = hold_idx_q;
            mem_mask  = hold_mask_q;
            mem_wdata = hold_wdata_q;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_mask[b]) mem[mem_widx][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    always_comb begin
        ext_lo   = mem[idx];
        ext_hi   = '0;
        ext_off  = off;
        ext_size = bus.req_size;
        ext_sx   = bus.req_sz_ex;
`ifdef D_MEM_MISALIGN_EN
        if (state_q == StSplit) begin
            ext_lo   = hold_lo_q;
            ext_hi   = mem[hold_idx_q];
            ext_off  = hold_off_q;
            ext_size = hold_size_q;
            ext_sx   = hold_sx_q;
        end
`endif
    end

    d_mem_ext u_ext (
        .lo_word (ext_lo),
        .hi_word (ext_hi),
        .offset  (ext_off),
        .size    (ext_size),
        .sz_ex   (ext_sx),
        .data    (ext_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
            for (int unsigned k = 0; k < IO_CHANNELS; k++) io_q[k] <= '0;
`ifdef D_MEM_MISALIGN_EN
            state_q      <= StIdle;
            ready_q      <= 1'b1;
            hold_idx_q   <= '0;
            hold_off_q   <= '0;
            hold_size_q  <= '0;
            hold_sx_q    <= 1'b0;
            hold_wr_q    <= 1'b0;
            hold_mask_q  <= '0;
            hold_wdata_q <= '0;
            hold_lo_q    <= '0;
`endif
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_data_q  <= '0;
            if (accept) begin
                if (err) begin
                    rsp_valid_q <= 1'b1;
                    rsp_err_q   <= 1'b1;
`ifdef D_MEM_MISALIGN_EN
                end else if (split) begin
                    state_q      <= StSplit;
                    ready_q      <= 1'b0;
                    hold_idx_q   <= idx_next;
                    hold_off_q   <= off;
                    hold_size_q  <= bus.req_size;
                    hold_sx_q    <= bus.req_sz_ex;
                    hold_wr_q    <= bus.req_wr_en;
                    hold_mask_q  <= hi_mask;
                    hold_wdata_q <= hi_wdata;
                    hold_lo_q    <= ext_lo;
`endif
                end else begin
                    rsp_valid_q <= 1'b1;
                    if (in_io) begin
                        if (bus.req_wr_en) io_q[io_idx] <= bus.req_wr_data;
                        else               rsp_data_q   <= io_q[io_idx];
                    end else if (!bus.req_wr_en) begin
                        rsp_data_q <= ext_data;
                    end
                end
            end
`ifdef D_MEM_MISALIGN_EN
            // No request can be accepted here, so this never overlaps the branch above.
            if (state_q == StSplit) begin
                state_q     <= StIdle;
                ready_q     <= 1'b1;
                rsp_valid_q <= 1'b1;
                rsp_data_q  <= hold_wr_q ? '0 : ext_data;
            end
`endif
        end
    end

`ifdef D_MEM_MISALIGN_EN
    assign bus.req_ready = ready_q;
`else
    assign bus.req_ready = 1'b1;
`endif
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_err   = rsp_err_q;
    assign bus.rsp_data  = rsp_data_q;

    for (genvar k = 0; k < IO_CHANNELS; k++) begin : g_io
        assign mem_map_io[BUS_WIDTH*k +: BUS_WIDTH] = io_q[k];
    end

endmodule
